// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator.
// Format select encoding and default widths.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_J   = 3'b011,
      IMM_U   = 3'b100,
      IMM_CSR = 3'b101
   } imm_src_e;

   localparam int IMM_XLEN_DEF  = 32;
   localparam int IMM_TAG_W_DEF = 5;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the fetch side, the immediate generator and decode.
// master drives instructions and out_ready; slave is the generator stage.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [2:0]       ImmSrc;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  ImmExt;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   modport master (
      output in_valid, instr, ImmSrc, in_tag, out_ready,
      input  in_ready, out_valid, ImmExt, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, instr, ImmSrc, in_tag, out_ready,
      output in_ready, out_valid, ImmExt, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate format mux; 101 is CSR zimm when IMM_CSR_EN is defined,
// otherwise illegal. Unsupported selects give imm=0 with illegal set.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   logic [31:0] imm32;
   logic        unused_opcode;

   assign unused_opcode = ^instr[6:0];

   always_comb begin
      imm32   = '0;
      illegal = 1'b0;
      case (imm_src_e'(imm_src))
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
`ifdef IMM_CSR_EN
         IMM_CSR: imm32 = {27'b0, instr[19:15]};
`endif
         default: illegal = 1'b1;
      endcase
   end

   // CSR zimm and illegal both have bit 31 clear, so sign extension is safe for all cases
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on input, 1-cycle latency, full throughput.
// 2-entry (out + skid) buffer; in_ready is registered (~skid_v), no comb path from out_ready.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = IMM_XLEN_DEF,
   parameter int TAG_W = IMM_TAG_W_DEF
) (
   input logic              clk,
   input logic              rst,
   imm_gen_pipe_if.slave    bus
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } imm_payload_t;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   imm_payload_t dec_p, out_q, skid_q;
   logic         out_v, skid_v;
   logic         accept, drain;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (bus.instr),
      .imm_src (bus.ImmSrc),
      .imm     (dec_p.imm),
      .illegal (dec_p.illegal)
   );
   assign dec_p.tag = bus.in_tag;

   assign accept = bus.in_valid & ~skid_v;
   assign drain  = ~out_v | bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (drain) begin
         // skid holds the older entry, so it must leave first
         if (skid_v) begin
            out_q <= skid_q;
            out_v <= 1'b1;
            if (accept) begin
               skid_q <= dec_p;
            end else begin
               skid_v <= 1'b0;
            end
         end else if (accept) begin
            out_q <= dec_p;
            out_v <= 1'b1;
         end else begin
            out_v <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= dec_p;
         skid_v <= 1'b1;
      end
   end

   assign bus.in_ready    = ~skid_v;
   assign bus.out_valid   = out_v;
   assign bus.ImmExt      = out_q.imm;
   assign bus.out_tag     = out_q.tag;
   assign bus.out_illegal = out_q.illegal;

endmodule
